// File: rtl/r5p_tb_ctl.sv
// Test controller on the TCB bus: signature bounds, halt/exit code, watchdog,
// free-running cycle counter and a console TX FIFO.
module r5p_tb_ctl #(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32,
  parameter int unsigned FD  = 16,
  parameter int unsigned TMO = 80000,
  parameter int unsigned CW  = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bus_vld_i,
  input  logic            bus_wen_i,
  input  logic [AW-1:0]   bus_adr_i,
  input  logic [DW/8-1:0] bus_ben_i,
  input  logic [DW-1:0]   bus_wdt_i,
  output logic [DW-1:0]   bus_rdt_o,
  output logic            bus_err_o,
  output logic            bus_rdy_o,
  output logic            con_vld_o,
  output logic [7:0]      con_dat_o,
  input  logic            con_rdy_i,
  output logic [DW-1:0]   sig_begin_o,
  output logic [DW-1:0]   sig_end_o,
  output logic            halt_o,
  output logic [DW-2:0]   exit_code_o,
  output logic            timeout_o
);

  localparam int unsigned BW  = DW / 8;
  localparam int unsigned FAW = $clog2(FD);

  localparam logic [5:0] OffSigBegin = 6'h00;
  localparam logic [5:0] OffSigEnd   = 6'h08;
  localparam logic [5:0] OffHalt     = 6'h10;
  localparam logic [5:0] OffCon      = 6'h18;
  localparam logic [5:0] OffTmo      = 6'h20;
  localparam logic [5:0] OffCycLo    = 6'h28;
  localparam logic [5:0] OffCycHi    = 6'h2C;

  function automatic logic [DW-1:0] ben_merge(input logic [DW-1:0] old_v,
                                              input logic [DW-1:0] new_v,
                                              input logic [BW-1:0] ben);
    logic [DW-1:0] res;
    res = old_v;
    for (int i = 0; i < int'(BW); i++) begin
      if (ben[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  logic [DW-1:0] sig_begin_q, sig_begin_d, sig_end_q, sig_end_d;
  logic [DW-1:0] tmo_q, tmo_d, wdg_q, wdg_d, shadow_q, shadow_d;
  logic [DW-1:0] rdt_q, rdt_d;
  logic          err_q, err_d, halt_q, halt_d, timeout_q, timeout_d;
  logic [DW-2:0] exit_q, exit_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [FAW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level;
  logic [7:0]    fifo_mem [FD];

  logic [5:0]      off;
  logic [2*DW-1:0] cyc_ext;
  logic            hit_sig_b, hit_sig_e, hit_halt, hit_con, hit_tmo, hit_cyc_lo, hit_cyc_hi;
  logic            hit_any, xfer, wr, rd, full, empty, push, pop;
  logic            unused_adr;

  assign off        = bus_adr_i[5:0];
  assign unused_adr = ^bus_adr_i[AW-1:6];
  assign hit_sig_b  = (off == OffSigBegin);
  assign hit_sig_e  = (off == OffSigEnd);
  assign hit_halt   = (off == OffHalt);
  assign hit_con    = (off == OffCon);
  assign hit_tmo    = (off == OffTmo);
  assign hit_cyc_lo = (off == OffCycLo);
  assign hit_cyc_hi = (DW == 32) && (off == OffCycHi);
  assign hit_any    = hit_sig_b | hit_sig_e | hit_halt | hit_con | hit_tmo |
                      hit_cyc_lo | hit_cyc_hi;

  assign cyc_ext = (2*DW)'(cyc_q);
  assign level   = wr_ptr_q - rd_ptr_q;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[FAW] != rd_ptr_q[FAW]) &&
                   (wr_ptr_q[FAW-1:0] == rd_ptr_q[FAW-1:0]);
  assign pop     = ~empty & con_rdy_i;

  // Only a console write into a full FIFO can stall, and a same-cycle pop frees a slot.
  assign bus_rdy_o = ~(bus_wen_i & hit_con) | ~full | pop;
  assign xfer      = bus_vld_i & bus_rdy_o;
  assign wr        = xfer & bus_wen_i & hit_any;
  assign rd        = xfer & ~bus_wen_i & hit_any;
  assign push      = wr & hit_con & bus_ben_i[0];

  always_comb begin
    sig_begin_d = sig_begin_q;
    sig_end_d   = sig_end_q;
    tmo_d       = tmo_q;
    wdg_d       = wdg_q;
    timeout_d   = timeout_q;
    halt_d      = halt_q;
    exit_d      = exit_q;
    shadow_d    = shadow_q;
    cyc_d       = halt_q ? cyc_q : cyc_q + CW'(1);
    wr_ptr_d    = wr_ptr_q + (FAW+1)'(push);
    rd_ptr_d    = rd_ptr_q + (FAW+1)'(pop);
    rdt_d       = '0;
    err_d       = 1'b0;

    if (wr && hit_sig_b) sig_begin_d = ben_merge(sig_begin_q, bus_wdt_i, bus_ben_i);
    if (wr && hit_sig_e) sig_end_d   = ben_merge(sig_end_q, bus_wdt_i, bus_ben_i);
    if (wr && hit_halt && bus_wdt_i[0]) begin
      halt_d = 1'b1;
      exit_d = bus_wdt_i[DW-1:1];
    end

    if (wr && hit_tmo) begin
      tmo_d = ben_merge(tmo_q, bus_wdt_i, bus_ben_i);
      wdg_d = '0;
    end else if ((tmo_q != '0) && !halt_q && !timeout_q) begin
      if (wdg_q == tmo_q - DW'(1)) timeout_d = 1'b1;
      wdg_d = wdg_q + DW'(1);
    end

    if (xfer && !hit_any) begin
      err_d = 1'b1;
    end else if (rd) begin
      case (off)
        OffSigBegin: rdt_d = sig_begin_q;
        OffSigEnd:   rdt_d = sig_end_q;
        OffCon:      rdt_d = DW'(level);
        OffTmo:      rdt_d = tmo_q;
        OffCycLo:    rdt_d = cyc_ext[DW-1:0];
        OffCycHi:    rdt_d = shadow_q;
        default:     rdt_d = '0;
      endcase
    end
    // Upper half is captured with the low read so a following high read is coherent.
    if (rd && hit_cyc_lo) shadow_d = cyc_ext[2*DW-1:DW];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_begin_q <= '0;
      sig_end_q   <= '0;
      tmo_q       <= DW'(TMO);
      wdg_q       <= '0;
      timeout_q   <= 1'b0;
      halt_q      <= 1'b0;
      exit_q      <= '0;
      shadow_q    <= '0;
      cyc_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rdt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      sig_begin_q <= sig_begin_d;
      sig_end_q   <= sig_end_d;
      tmo_q       <= tmo_d;
      wdg_q       <= wdg_d;
      timeout_q   <= timeout_d;
      halt_q      <= halt_d;
      exit_q      <= exit_d;
      shadow_q    <= shadow_d;
      cyc_q       <= cyc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rdt_q       <= rdt_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[FAW-1:0]] <= bus_wdt_i[7:0];
  end

  assign con_vld_o   = ~empty;
  assign con_dat_o   = fifo_mem[rd_ptr_q[FAW-1:0]];
  assign bus_rdt_o   = rdt_q;
  assign bus_err_o   = err_q;
  assign sig_begin_o = sig_begin_q;
  assign sig_end_o   = sig_end_q;
  assign halt_o      = halt_q;
  assign exit_code_o = exit_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_r5p_tb_ctl.sv
// Scoreboard bench for r5p_tb_ctl: a cycle-level reference model predicts bus responses,
// status outputs and console bytes; separate monitors compare what the DUT presents.
module tb_r5p_tb_ctl;
  localparam int unsigned DW   = 32;
  localparam int unsigned FD   = 16;
  localparam int unsigned TMO0 = 80000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus_vld = 1'b0, bus_wen = 1'b0, con_rdy = 1'b0;
  logic [31:0] bus_adr = '0, bus_wdt = '0;
  logic [3:0]  bus_ben = '0;
  logic [31:0] bus_rdt, sig_begin, sig_end;
  logic        bus_err, bus_rdy, con_vld, halt, timeout;
  logic [7:0]  con_dat;
  logic [30:0] exit_code;

  always #10 clk = ~clk;

  r5p_tb_ctl #(.AW(32), .DW(DW), .FD(FD), .TMO(TMO0), .CW(64)) dut (
    .clk(clk), .rst(rst),
    .bus_vld_i(bus_vld), .bus_wen_i(bus_wen), .bus_adr_i(bus_adr), .bus_ben_i(bus_ben),
    .bus_wdt_i(bus_wdt), .bus_rdt_o(bus_rdt), .bus_err_o(bus_err), .bus_rdy_o(bus_rdy),
    .con_vld_o(con_vld), .con_dat_o(con_dat), .con_rdy_i(con_rdy),
    .sig_begin_o(sig_begin), .sig_end_o(sig_end), .halt_o(halt),
    .exit_code_o(exit_code), .timeout_o(timeout)
  );

  // Reference model state
  logic [31:0] m_sig_b, m_sig_e, m_tmo, m_shadow;
  logic        m_halt, m_timeout;
  logic [30:0] m_exit;
  logic [63:0] m_cyc;
  int          m_level;
  longint      m_edge, m_deadline;
  logic [7:0]  con_q [$];
  logic [31:0] exp_rdt_q [$];
  logic        exp_err_q [$];
  string       exp_tag_q [$];
  bit          last_hs;
  int          n_cmp = 0, n_fail = 0;
  logic [5:0]  offs [9] = '{6'h00, 6'h08, 6'h18, 6'h20, 6'h28, 6'h2C, 6'h30, 6'h3C, 6'h04};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] b);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = b[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_sig_b = '0; m_sig_e = '0; m_tmo = TMO0; m_shadow = '0;
    m_halt = 1'b0; m_timeout = 1'b0; m_exit = '0; m_cyc = '0; m_level = 0;
    m_edge = 0; m_deadline = longint'(TMO0);
    con_q.delete();
  endtask

  // One clock: check status against the model, then apply the edge to the model.
  task automatic tick();
    logic [5:0]  off;
    logic [31:0] rv;
    bit          pop, rdy, hs, valid, er, tmo_wr, halt_pre;
    logic [31:0] tmo_pre;
    #1;
    off = bus_adr[5:0];
    pop = (m_level > 0) && con_rdy;
    rdy = !(bus_wen && off == 6'h18 && m_level == int'(FD) && !pop);
    chk("halt", halt, m_halt);
    chk("exit_code", exit_code, m_exit);
    chk("timeout", timeout, m_timeout);
    chk("sig_begin", sig_begin, m_sig_b);
    chk("sig_end", sig_end, m_sig_e);
    chk("con_vld", con_vld, m_level != 0);
    chk("bus_rdy", bus_rdy, rdy);
    @(posedge clk);
    rv = '0; er = 1'b0; hs = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      hs = bus_vld && rdy;
      valid = off inside {6'h00, 6'h08, 6'h10, 6'h18, 6'h20, 6'h28, 6'h2C};
      if (hs && !valid) er = 1'b1;
      else if (hs && !bus_wen) begin
        case (off)
          6'h00: rv = m_sig_b;
          6'h08: rv = m_sig_e;
          6'h18: rv = 32'(m_level);
          6'h20: rv = m_tmo;
          6'h28: begin rv = m_cyc[31:0]; m_shadow = m_cyc[63:32]; end
          6'h2C: rv = m_shadow;
          default: rv = '0;
        endcase
      end
      halt_pre = m_halt; tmo_pre = m_tmo; tmo_wr = 1'b0;
      m_edge++;
      if (hs && bus_wen && valid) begin
        case (off)
          6'h00: m_sig_b = bmerge(m_sig_b, bus_wdt, bus_ben);
          6'h08: m_sig_e = bmerge(m_sig_e, bus_wdt, bus_ben);
          6'h10: if (bus_wdt[0]) begin m_halt = 1'b1; m_exit = bus_wdt[31:1]; end
          6'h18: if (bus_ben[0]) begin con_q.push_back(bus_wdt[7:0]); m_level++; end
          6'h20: begin
            m_tmo = bmerge(m_tmo, bus_wdt, bus_ben); tmo_wr = 1'b1;
            m_deadline = m_edge + longint'(m_tmo);
          end
          default: ;
        endcase
      end
      // Expiry lands exactly TMO edges after the last load, unless halted first.
      if (!tmo_wr && !halt_pre && !m_timeout && tmo_pre != 0 && m_edge == m_deadline)
        m_timeout = 1'b1;
      if (!halt_pre) m_cyc++;
      if (pop) m_level--;
    end
    exp_rdt_q.push_back(rv);
    exp_err_q.push_back(er);
    exp_tag_q.push_back($sformatf("%s@%02h", bus_wen ? "wr" : "rd", off));
    last_hs = hs;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus_vld = 1'b0;
    repeat (n) tick();
  endtask

  task automatic bus(input bit wen, input logic [5:0] off, input logic [31:0] wdt,
                     input logic [3:0] ben);
    bus_vld = 1'b1; bus_wen = wen; bus_adr = {26'($urandom()), off};
    bus_wdt = wdt; bus_ben = ben;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (last_hs) break;
    end
    if (!last_hs) begin
      n_cmp++; n_fail++;
      $display("FAIL bus_accept: got 0 expected 1 (off %02h)", off);
    end
    bus_vld = 1'b0;
  endtask

  task automatic mon_bus();
    logic [31:0] e_rdt;
    logic        e_err;
    string       tag;
    forever begin
      @(negedge clk);
      #2;
      if (exp_rdt_q.size() > 0) begin
        e_rdt = exp_rdt_q.pop_front(); e_err = exp_err_q.pop_front();
        tag = exp_tag_q.pop_front();
        chk({"rdt ", tag}, bus_rdt, e_rdt);
        chk({"err ", tag}, bus_err, e_err);
      end
    end
  endtask

  task automatic mon_con();
    forever begin
      @(negedge clk);
      #2;
      if (con_vld && con_rdy) begin
        if (con_q.size() == 0) chk("con_unexpected", 1, 0);
        else chk("con_dat", con_dat, con_q.pop_front());
      end
    end
  endtask

  initial begin
    logic [5:0]  off;
    logic [31:0] wdt;
    bit          wen;
    int          n;
    model_reset();
    fork
      mon_bus();
      mon_con();
    join_none
    @(negedge clk);
    idle(2);
    rst = 1'b0;
    idle(1);

    // Signature bounds
    bus(1, 6'h00, 32'h1000, 4'hF);
    bus(1, 6'h08, 32'h1040, 4'hF);
    bus(0, 6'h00, '0, 4'hF);
    bus(0, 6'h08, '0, 4'hF);
    bus(1, 6'h00, 32'hAB00_2000, 4'b0101);
    bus(0, 6'h00, '0, 4'hF);

    // Unmapped offset
    bus(0, 6'h30, '0, 4'hF);
    bus(1, 6'h30, 32'hDEAD_BEEF, 4'hF);
    bus(0, 6'h00, '0, 4'hF);
    bus(0, 6'h20, '0, 4'hF);

    // Watchdog load, rewrite at 50, expiry 100 cycles later
    bus(1, 6'h20, 32'd100, 4'hF);
    idle(49);
    bus(1, 6'h20, 32'd100, 4'hF);
    idle(110);

    // Console FIFO fill, stall and drain
    con_rdy = 1'b0;
    for (int i = 0; i < 16; i++) bus(1, 6'h18, 32'h41 + 32'(i), 4'h1);
    bus(0, 6'h18, '0, 4'hF);
    bus_vld = 1'b1; bus_wen = 1'b1; bus_adr = 32'h0020_0018; bus_wdt = 32'h7A; bus_ben = 4'h1;
    repeat (3) tick();
    con_rdy = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!last_hs && n < 8);
    bus_vld = 1'b0;
    n = 0;
    while (m_level != 0 && n < 40) begin tick(); n++; end
    idle(2);
    chk("fifo_drained", con_q.size(), 0);

    // Coherent 64-bit counter read across the 32-bit carry
    force dut.cyc_q = 64'h0000_0000_FFFF_FFFF;
    release dut.cyc_q;
    m_cyc = 64'h0000_0000_FFFF_FFFF;
    idle(1);
    bus(0, 6'h28, '0, 4'hF);
    bus(0, 6'h2C, '0, 4'hF);

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      con_rdy = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) idle(1);
      else begin
        off = offs[$urandom_range(0, 8)];
        wen = 1'($urandom_range(0, 1));
        wdt = (off == 6'h20) ? 32'($urandom_range(20, 400)) : $urandom();
        if (wen && off == 6'h18 && m_level == int'(FD)) con_rdy = 1'b1;
        bus(wen, off, wdt, 4'($urandom()));
      end
    end

    // Halt: sticky, freezes the counter, clear-write ignored
    con_rdy = 1'b0;
    bus(1, 6'h18, 32'h5A, 4'h1);
    bus(1, 6'h00, 32'h0000_ABCD, 4'hF);
    bus(1, 6'h10, 32'h55, 4'hF);
    bus(0, 6'h28, '0, 4'hF);
    idle(5);
    bus(0, 6'h28, '0, 4'hF);
    bus(1, 6'h10, 32'h0, 4'hF);
    idle(2);

    // Asynchronous reset in the middle of a transfer
    bus_vld = 1'b1; bus_wen = 1'b0; bus_adr = 32'h0020_0000; bus_ben = 4'hF;
    tick();
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst bus_rdt", bus_rdt, 0);
    chk("rst bus_err", bus_err, 0);
    chk("rst halt", halt, 0);
    chk("rst exit_code", exit_code, 0);
    chk("rst timeout", timeout, 0);
    chk("rst sig_begin", sig_begin, 0);
    chk("rst sig_end", sig_end, 0);
    chk("rst con_vld", con_vld, 0);
    bus_vld = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    idle(3);
    bus(0, 6'h20, '0, 4'hF);
    bus(0, 6'h18, '0, 4'hF);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
